// File: rtl/usd_sensor_emulator.sv
`timescale 1ns/1ps
// usd_sensor_emulator
// Behavioural stand-in for an ultrasonic ranging sensor (sensor side of the
// trigger/echo link). A trigger pulse is synchronised and width-checked.
// After the programmed time of flight an echo pulse of fixed width is driven back.
//
// Ports
//   clk_50mhz   in   1   the only clock
//   rst_n       in   1   synchronous, active-low reset
//   enable      in   1   1 = respond to triggers, 0 = force IDLE
//   trigger_in  in   1   trigger from initiator (asynchronous, 3-flop synchronised)
//   delay_us    in   16  time of flight in us, sampled when a trigger is accepted
//   echo_out    out  1   registered echo line
//   busy        out  1   high in TRIG/DELAY/ECHO
//   trig_error  out  1   one-cycle pulse when a trigger is too short
//   echo_count  out  16  completed echoes, wraps
module usd_sensor_emulator #(
    parameter int unsigned CLKS_PER_US  = 50,
    parameter int unsigned MIN_TRIG_US  = 10,
    parameter int unsigned ECHO_US      = 100,
    parameter int unsigned MAX_DELAY_US = 10000
) (
    input  logic        clk_50mhz,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        trigger_in,
    input  logic [15:0] delay_us,
    output logic        echo_out,
    output logic        busy,
    output logic        trig_error,
    output logic [15:0] echo_count
);

    localparam int unsigned MIN_TRIG_CLKS = MIN_TRIG_US * CLKS_PER_US;
    localparam int unsigned ECHO_CLKS     = ECHO_US * CLKS_PER_US;
    localparam int unsigned CNT_MAX       = (MIN_TRIG_CLKS > ECHO_CLKS) ? MIN_TRIG_CLKS : ECHO_CLKS;
    localparam int unsigned CW            = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam int unsigned PW            = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int unsigned UW            = (MAX_DELAY_US > 0) ? $clog2(MAX_DELAY_US + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRIG  = 2'd1,
        DELAY = 2'd2,
        ECHO  = 2'd3
    } state_t;

    state_t          state_q;
    logic [2:0]      sync_q;
    logic            tp_q;
    logic [CW-1:0]   cnt_q;        // trigger width in TRIG, echo length in ECHO
    logic [PW-1:0]   pre_q;        // clocks within the current microsecond
    logic [UW-1:0]   us_q;         // elapsed microseconds in DELAY
    logic [UW-1:0]   delay_q;      // clamped time of flight
    logic            echo_q;
    logic            busy_q;
    logic            trig_error_q;
    logic [15:0]     echo_count_q;

    logic            t;
    logic [UW-1:0]   delay_clamped_d;

    assign t = sync_q[2];

    always_comb begin
        if (32'(delay_us) > MAX_DELAY_US) begin
            delay_clamped_d = UW'(MAX_DELAY_US);
        end else begin
            delay_clamped_d = UW'(delay_us);
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            tp_q         <= 1'b0;
            cnt_q        <= '0;
            pre_q        <= '0;
            us_q         <= '0;
            delay_q      <= '0;
            echo_q       <= 1'b0;
            busy_q       <= 1'b0;
            trig_error_q <= 1'b0;
            echo_count_q <= '0;
        end else begin
            sync_q       <= {sync_q[1:0], trigger_in};
            tp_q         <= t;
            trig_error_q <= 1'b0;

            if (!enable) begin
                // Abort anything in progress; an aborted echo is not counted.
                state_q <= IDLE;
                echo_q  <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        echo_q <= 1'b0;
                        busy_q <= 1'b0;
                        // Only a fresh rising edge is accepted, so a trigger
                        // still high when returning here is ignored.
                        if (t && !tp_q) begin
                            state_q <= TRIG;
                            busy_q  <= 1'b1;
                            // The detecting edge already saw t high, so it
                            // counts as the first clock of the pulse.
                            cnt_q   <= CW'(1);
                        end
                    end
                    TRIG: begin
                        if (t) begin
                            if (cnt_q < CW'(MIN_TRIG_CLKS)) begin
                                cnt_q <= cnt_q + CW'(1);
                            end
                        end else if (cnt_q >= CW'(MIN_TRIG_CLKS)) begin
                            delay_q <= delay_clamped_d;
                            pre_q   <= '0;
                            us_q    <= '0;
                            state_q <= DELAY;
                        end else begin
                            trig_error_q <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= IDLE;
                        end
                    end
                    DELAY: begin
                        // Entry is 3 clocks after the pin fell; the echo
                        // register adds one more, giving D*CLKS_PER_US+4.
                        if (us_q == delay_q) begin
                            echo_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ECHO;
                        end else if (pre_q == PW'(CLKS_PER_US - 1)) begin
                            pre_q <= '0;
                            us_q  <= us_q + UW'(1);
                        end else begin
                            pre_q <= pre_q + PW'(1);
                        end
                    end
                    ECHO: begin
                        if (cnt_q == CW'(ECHO_CLKS - 1)) begin
                            echo_q       <= 1'b0;
                            busy_q       <= 1'b0;
                            echo_count_q <= echo_count_q + 16'd1;
                            state_q      <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        echo_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign echo_out   = echo_q;
    assign busy       = busy_q;
    assign trig_error = trig_error_q;
    assign echo_count = echo_count_q;

endmodule

// File: tb/tb_usd_sensor_emulator.sv
`timescale 1ns/1ps
// Directed bench for usd_sensor_emulator, scaled down so every scenario fits a
// short run: 5 clocks/us, 50-clock minimum trigger, 100-clock echo, 100 us
// (500 clock) time-of-flight clamp.
module tb_usd_sensor_emulator;

    localparam int C   = 5;
    localparam int MIN = 10;
    localparam int EUS = 20;
    localparam int MAX = 100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        trigger_in;
    logic [15:0] delay_us;
    logic        echo_out;
    logic        busy;
    logic        trig_error;
    logic [15:0] echo_count;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int f_cyc     = 0;
    int lat;
    int wid;
    bit busy_drop;
    bit err_seen;
    bit echo_seen;

    usd_sensor_emulator #(
        .CLKS_PER_US (C),
        .MIN_TRIG_US (MIN),
        .ECHO_US     (EUS),
        .MAX_DELAY_US(MAX)
    ) dut (
        .clk_50mhz (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .trigger_in(trigger_in),
        .delay_us  (delay_us),
        .echo_out  (echo_out),
        .busy      (busy),
        .trig_error(trig_error),
        .echo_count(echo_count)
    );

    always #10 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (trig_error) err_seen = 1'b1;
            if (echo_out) echo_seen = 1'b1;
        end
    endtask

    task automatic step_mon(input int n);
        for (int i = 0; i < n; i++) begin
            step(1);
            if (!busy) busy_drop = 1'b1;
        end
    endtask

    // Trigger held high for n edges; f_cyc is the first edge that samples 0.
    task automatic trig_pulse(input int n);
        trigger_in = 1'b1;
        step(n);
        trigger_in = 1'b0;
        f_cyc = cyc + 1;
    endtask

    task automatic wait_rise(input int budget, output int l);
        int k;
        k = 0;
        while (!echo_out && k < budget) begin
            step_mon(1);
            k++;
        end
        l = echo_out ? (cyc - f_cyc) : -1;
    endtask

    task automatic meas_high(input int budget, output int w);
        w = 0;
        while (echo_out && w < budget) begin
            step(1);
            w++;
            if (echo_out && !busy) busy_drop = 1'b1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        trigger_in = 1'b0;
        delay_us   = 16'd0;
        busy_drop  = 1'b0;
        err_seen   = 1'b0;
        echo_seen  = 1'b0;
        step(3);
        chk("rst_echo", echo_out, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_trig_error", trig_error, 1'b0);
        chk("rst_echo_count", echo_count, 16'd0);
        rst_n = 1'b1;
        step(5);

        // 1: minimum-width trigger, 10 us flight -> 10*5+4 clocks
        delay_us = 16'd10;
        trig_pulse(MIN * C);
        busy_drop = 1'b0;
        wait_rise(2000, lat);
        chk("t1_latency", lat, 32'd54);
        meas_high(2000, wid);
        chk("t1_width", wid, 32'd100);
        chk("t1_count", echo_count, 16'd1);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_busy_held", busy_drop, 1'b0);
        chk("t1_no_error", err_seen, 1'b0);
        step(5);

        // 2: one clock short -> single trig_error pulse, no echo
        trig_pulse(MIN * C - 1);
        step(3);
        chk("t2_err_early", trig_error, 1'b0);
        step(1);
        chk("t2_err_pulse", trig_error, 1'b1);
        chk("t2_busy_idle", busy, 1'b0);
        step(1);
        chk("t2_err_one_cycle", trig_error, 1'b0);
        echo_seen = 1'b0;
        step(700);
        chk("t2_no_echo", echo_seen, 1'b0);
        chk("t2_count", echo_count, 16'd1);
        err_seen = 1'b0;

        // 3: over-range delay clamps to MAX; zero delay gives pipeline latency only
        delay_us = 16'd1000;
        trig_pulse(MIN * C);
        wait_rise(2000, lat);
        chk("t3_clamp_latency", lat, 32'd504);
        meas_high(2000, wid);
        delay_us = 16'd0;
        step(3);
        trig_pulse(MIN * C);
        wait_rise(2000, lat);
        chk("t3_zero_latency", lat, 32'd4);
        meas_high(2000, wid);
        chk("t3_count", echo_count, 16'd3);
        step(3);

        // 4: second trigger during DELAY is ignored
        delay_us = 16'd20;
        trig_pulse(MIN * C);
        busy_drop = 1'b0;
        step_mon(3 + 5);
        trigger_in = 1'b1;
        step_mon(MIN * C);
        trigger_in = 1'b0;
        wait_rise(2000, lat);
        chk("t4_latency", lat, 32'd104);
        meas_high(2000, wid);
        chk("t4_width", wid, 32'd100);
        chk("t4_busy_held", busy_drop, 1'b0);
        echo_seen = 1'b0;
        step(300);
        chk("t4_single_echo", echo_seen, 1'b0);
        chk("t4_count", echo_count, 16'd4);
        chk("t4_no_error", err_seen, 1'b0);

        // 5: enable dropped mid-echo aborts without counting
        delay_us = 16'd0;
        trig_pulse(MIN * C);
        wait_rise(2000, lat);
        step(10);
        chk("t5_echo_before", echo_out, 1'b1);
        enable = 1'b0;
        step(1);
        chk("t5_echo_off", echo_out, 1'b0);
        chk("t5_busy_off", busy, 1'b0);
        chk("t5_count", echo_count, 16'd4);
        enable = 1'b1;
        echo_seen = 1'b0;
        step(200);
        chk("t5_stays_idle", echo_seen, 1'b0);

        // 6: reset mid-DELAY, then a normal echo after release
        delay_us = 16'd50;
        trig_pulse(MIN * C);
        step(3 + 20);
        chk("t6_busy_delay", busy, 1'b1);
        rst_n = 1'b0;
        step(1);
        chk("t6_rst_echo", echo_out, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_count", echo_count, 16'd0);
        rst_n = 1'b1;
        step(5);
        delay_us = 16'd10;
        trig_pulse(MIN * C);
        wait_rise(2000, lat);
        chk("t6_latency", lat, 32'd54);
        meas_high(2000, wid);
        chk("t6_width", wid, 32'd100);
        chk("t6_count", echo_count, 16'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
